// File: rtl/seg_scan_decoder.sv
// Receive side of a 4-digit multiplexed seven-segment link: synchronizes and debounces
// each anode dwell, decodes segments back to BCD and strobes out complete frames.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int CNT_W          = 24
) (
    input  logic        sysclock,
    input  logic        reset,
    input  logic [3:0]  anode_in,
    input  logic [7:0]  seg_in,
    output logic [15:0] digits,
    output logic [3:0]  dp_out,
    output logic [3:0]  bad_code,
    output logic        frame_valid,
    output logic        frame_err
);

    typedef enum logic [1:0] {HUNT, COLLECT, FRAME_DONE} state_t;

    localparam logic [CNT_W-1:0] STAB_ACC = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_SAT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [11:0]      sync1_q, sync2_q, samp_q;
    logic [CNT_W-1:0] stab_cnt_q;
    logic             accept;
    logic [3:0]       acc_an;
    logic [7:0]       acc_seg;

    always_ff @(posedge sysclock or posedge reset) begin
        if (reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            samp_q     <= '1;
            stab_cnt_q <= '0;
        end else begin
            sync1_q <= {anode_in, seg_in};
            sync2_q <= sync1_q;
            samp_q  <= sync2_q;
            if (sync2_q != samp_q)
                stab_cnt_q <= '0;
            else if (stab_cnt_q != STAB_SAT)
                stab_cnt_q <= stab_cnt_q + 1'b1;
        end
    end

    // Count saturates one past the accept value so the strobe fires once per dwell.
    assign accept            = (stab_cnt_q == STAB_ACC);
    assign {acc_an, acc_seg} = samp_q;

    logic [3:0] dec_nib;
    logic       dec_bad;
    logic       is_blank, is_digit;
    logic [1:0] dig_k;

    always_comb begin
        dec_nib = 4'hF;
        dec_bad = 1'b0;
        case (acc_seg[6:0])
            7'h40:   dec_nib = 4'd0;
            7'h79:   dec_nib = 4'd1;
            7'h24:   dec_nib = 4'd2;
            7'h30:   dec_nib = 4'd3;
            7'h19:   dec_nib = 4'd4;
            7'h12:   dec_nib = 4'd5;
            7'h02:   dec_nib = 4'd6;
            7'h78:   dec_nib = 4'd7;
            7'h00:   dec_nib = 4'd8;
            7'h10:   dec_nib = 4'd9;
            default: dec_bad = 1'b1;
        endcase
    end

    always_comb begin
        is_blank = (acc_an == 4'hF);
        is_digit = 1'b1;
        dig_k    = 2'd0;
        case (acc_an)
            4'b1110: dig_k = 2'd0;
            4'b1101: dig_k = 2'd1;
            4'b1011: dig_k = 2'd2;
            4'b0111: dig_k = 2'd3;
            default: is_digit = 1'b0;
        endcase
    end

    state_t           state_q, state_d;
    logic [1:0]       exp_q, exp_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             wr_en, pub, fv_d, fe_d, dig_acc;

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        to_cnt_d = to_cnt_q;
        wr_en    = 1'b0;
        pub      = 1'b0;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        dig_acc  = accept && !is_blank;
        case (state_q)
            HUNT: begin
                to_cnt_d = '0;
                if (dig_acc && is_digit && dig_k == 2'd0) begin
                    wr_en   = 1'b1;
                    exp_d   = 2'd1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (dig_acc) begin
                    to_cnt_d = '0;
                    if (!is_digit) begin
                        fe_d    = 1'b1;
                        state_d = HUNT;
                    end else if (dig_k == exp_q) begin
                        wr_en = 1'b1;
                        if (dig_k == 2'd3) begin
                            pub     = 1'b1;
                            fv_d    = 1'b1;
                            state_d = FRAME_DONE;
                        end else begin
                            exp_d = exp_q + 2'd1;
                        end
                    end else if (dig_k == 2'd0) begin
                        // A fresh digit 0 restarts the frame rather than dropping to hunt.
                        fe_d  = 1'b1;
                        wr_en = 1'b1;
                        exp_d = 2'd1;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = HUNT;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    fe_d     = 1'b1;
                    to_cnt_d = '0;
                    state_d  = HUNT;
                end
            end
            FRAME_DONE: state_d = HUNT;
            default:    state_d = HUNT;
        endcase
    end

    logic [3:0][3:0] sh_nib_q, sh_nib_d;
    logic [3:0]      sh_dp_q, sh_dp_d, sh_bad_q, sh_bad_d;

    always_comb begin
        sh_nib_d = sh_nib_q;
        sh_dp_d  = sh_dp_q;
        sh_bad_d = sh_bad_q;
        if (wr_en) begin
            sh_nib_d[dig_k] = dec_nib;
            sh_dp_d[dig_k]  = acc_seg[7];
            sh_bad_d[dig_k] = dec_bad;
        end
    end

    logic [15:0] digits_q;
    logic [3:0]  dp_q, bad_q;
    logic        fv_q, fe_q;

    // Outputs load on the digit-3 accept so they are already new while frame_valid is high.
    always_ff @(posedge sysclock or posedge reset) begin
        if (reset) begin
            state_q  <= HUNT;
            exp_q    <= 2'd0;
            to_cnt_q <= '0;
            sh_nib_q <= '0;
            sh_dp_q  <= '1;
            sh_bad_q <= '0;
            digits_q <= 16'h0000;
            dp_q     <= 4'hF;
            bad_q    <= 4'h0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            to_cnt_q <= to_cnt_d;
            sh_nib_q <= sh_nib_d;
            sh_dp_q  <= sh_dp_d;
            sh_bad_q <= sh_bad_d;
            if (pub) begin
                digits_q <= sh_nib_d;
                dp_q     <= sh_dp_d;
                bad_q    <= sh_bad_d;
            end
            fv_q <= fv_d;
            fe_q <= fe_d;
        end
    end

    assign digits      = digits_q;
    assign dp_out      = dp_q;
    assign bad_code    = bad_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed and random dwell sequences checked against a
// frame-level reference model built from queue length and a segment lookup table.
module tb_seg_scan_decoder;

    localparam int STABLE   = 16;
    localparam int TIMEOUT  = 2000;
    localparam int LONG_MIN = 30;

    logic        sysclock = 1'b0;
    logic        reset    = 1'b1;
    logic [3:0]  anode_in = 4'hF;
    logic [7:0]  seg_in   = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  dp_out, bad_code;
    logic        frame_valid, frame_err;

    seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(24)) dut (
        .sysclock(sysclock), .reset(reset), .anode_in(anode_in), .seg_in(seg_in),
        .digits(digits), .dp_out(dp_out), .bad_code(bad_code),
        .frame_valid(frame_valid), .frame_err(frame_err)
    );

    always #5 sysclock = ~sysclock;

    int n_chk = 0, n_err = 0;
    int nv = 0, ne = 0;
    logic both_seen = 1'b0;

    always @(posedge sysclock) begin
        if (frame_valid) nv <= nv + 1;
        if (frame_err)   ne <= ne + 1;
        if (frame_valid && frame_err) both_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a frame is the list of digits received so far in order.
    logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0] ILL [11] = '{4'b1100, 4'b1010, 4'b0110, 4'b0000, 4'b1001, 4'b0101,
                             4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    int              fr_n;
    logic [3:0][3:0] fr_nib;
    logic [3:0]      fr_dp, fr_bad;
    logic [15:0]     m_digits;
    logic [3:0]      m_dp, m_bad;
    int              m_nv, m_ne;
    logic [11:0]     last_pat;

    function automatic void model_reset();
        fr_n = 0; m_digits = 16'h0000; m_dp = 4'hF; m_bad = 4'h0;
    endfunction

    function automatic void store(input int k, input logic [7:0] sg);
        fr_nib[k] = 4'hF;
        fr_bad[k] = 1'b1;
        for (int i = 0; i < 10; i++)
            if (SEG_TBL[i] == sg[6:0]) begin
                fr_nib[k] = 4'(i);
                fr_bad[k] = 1'b0;
            end
        fr_dp[k] = sg[7];
    endfunction

    function automatic void model_event(input logic [3:0] an, input logic [7:0] sg);
        int k;
        if (an == 4'hF) return;
        k = -1;
        if ($countones(~an) == 1)
            for (int i = 0; i < 4; i++) if (!an[i]) k = i;
        if (k < 0) begin
            if (fr_n > 0) begin m_ne++; fr_n = 0; end
        end else if (k == fr_n) begin
            store(k, sg);
            fr_n++;
            if (fr_n == 4) begin
                m_digits = fr_nib; m_dp = fr_dp; m_bad = fr_bad; m_nv++; fr_n = 0;
            end
        end else if (fr_n > 0) begin
            m_ne++;
            fr_n = 0;
            if (k == 0) begin store(0, sg); fr_n = 1; end
        end
    endfunction

    function automatic void model_timeout();
        if (fr_n > 0) begin m_ne++; fr_n = 0; end
    endfunction

    task automatic dwell(input logic [3:0] an, input logic [7:0] sg, input int len);
        anode_in = an;
        seg_in   = sg;
        last_pat = {an, sg};
        repeat (len) @(posedge sysclock);
        #1;
        if (len >= LONG_MIN) model_event(an, sg);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_digits"}, 32'(digits),   32'(m_digits));
        chk({tag, "_dp"},     32'(dp_out),   32'(m_dp));
        chk({tag, "_bad"},    32'(bad_code), 32'(m_bad));
        chk({tag, "_nvalid"}, 32'(nv),       32'(m_nv));
        chk({tag, "_nerr"},   32'(ne),       32'(m_ne));
    endtask

    task automatic frame(input logic [7:0] s0, s1, s2, s3);
        dwell(4'hE, s0, 64);
        dwell(4'hD, s1, 64);
        dwell(4'hB, s2, 64);
        dwell(4'h7, s3, 64);
    endtask

    initial begin
        int gap, r, k, ne0;
        logic [3:0] an;
        logic [7:0] sg;
        m_nv = 0; m_ne = 0; last_pat = '1;
        model_reset();

        // Reset state
        repeat (3) @(posedge sysclock);
        #1 reset = 1'b0;
        repeat (10) @(posedge sysclock);
        #1;
        check_all("reset");
        chk("reset_fv", 32'(frame_valid), 32'd0);
        chk("reset_fe", 32'(frame_err), 32'd0);

        // Basic frame then four more
        frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
        check_all("f1");
        chk("f1_const", 32'(digits), 32'h4321);
        repeat (4) frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
        check_all("f4");
        chk("f4_count", 32'(nv), 32'd5);
        chk("f4_noerr", 32'(ne), 32'd0);

        // Short glitch early in the digit-1 dwell
        dwell(4'hE, 8'hF9, 64);
        dwell(4'hD, 8'hA4, 2);
        dwell(4'hD, 8'h80, 5);
        dwell(4'hD, 8'hA4, 57);
        dwell(4'hB, 8'hB0, 64);
        dwell(4'h7, 8'h99, 64);
        check_all("glitch");
        chk("glitch_const", 32'(digits), 32'h4321);

        // Digit 0 then digit 2
        dwell(4'hE, 8'hF9, 64);
        dwell(4'hB, 8'hB0, 64);
        dwell(4'h7, 8'h99, 64);
        check_all("skip");
        chk("skip_err", 32'(ne), 32'd1);

        // Unrecognised pattern on digit 2
        frame(8'hF9, 8'hA4, 8'hFF, 8'h99);
        check_all("bad");
        chk("bad_const", 32'({digits, bad_code}), 32'h4F214);

        // Random dwell sequences
        gap = 0;
        for (int n = 0; n < 70; n++) begin
            r = $urandom_range(0, 99);
            if (gap > 900) r = 99;
            if (r < 15) begin
                an = 4'($urandom); sg = 8'($urandom);
                if ({an, sg} == last_pat) sg[7] = ~sg[7];
                dwell(an, sg, $urandom_range(3, 10));
                gap += 10;
            end else if (r < 25) begin
                an = 4'hF; sg = 8'($urandom);
                if ({an, sg} == last_pat) sg[7] = ~sg[7];
                dwell(an, sg, $urandom_range(LONG_MIN, 80));
                gap += 80;
                check_all("rnd_blank");
            end else begin
                if (r < 33) an = ILL[$urandom_range(0, 10)];
                else begin
                    k = ($urandom_range(0, 9) < 7) ? fr_n : $urandom_range(0, 3);
                    an = ~(4'b0001 << k);
                end
                if ($urandom_range(0, 9) < 8) sg = {1'($urandom), SEG_TBL[$urandom_range(0, 9)]};
                else sg = 8'($urandom);
                if ({an, sg} == last_pat) sg[7] = ~sg[7];
                dwell(an, sg, $urandom_range(LONG_MIN, 80));
                gap = 0;
                check_all("rnd");
            end
        end

        // Mid-frame timeout
        dwell(4'hE, 8'hF9, 64);
        dwell(4'hD, 8'hA4, 64);
        ne0 = ne;
        anode_in = 4'hF; seg_in = 8'hFF; last_pat = '1;
        repeat (TIMEOUT - 100) @(posedge sysclock);
        #1;
        chk("to_early", 32'(ne), 32'(ne0));
        for (int c = 0; c < 300 && ne == ne0; c++) @(posedge sysclock);
        #1;
        model_timeout();
        check_all("timeout");
        repeat (20) @(posedge sysclock);
        #1;

        // Reset in the middle of digit 2
        dwell(4'hE, 8'hF9, 64);
        dwell(4'hD, 8'hA4, 64);
        anode_in = 4'hB; seg_in = 8'hB0;
        repeat (30) @(posedge sysclock);
        #1 reset = 1'b1;
        #2;
        model_reset();
        check_all("rst_mid");
        chk("rst_mid_fv", 32'(frame_valid), 32'd0);
        chk("rst_mid_fe", 32'(frame_err), 32'd0);
        repeat (3) @(posedge sysclock);
        #1 reset = 1'b0;
        dwell(4'hB, 8'hB0, 40);
        frame(8'h90, 8'h80, 8'hF8, 8'h82);
        check_all("after_rst");
        chk("after_rst_const", 32'(digits), 32'h6789);

        chk("excl", 32'(both_seen), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
